// File: rtl/dmem_arbiter_pkg.sv
// Shared owner-tag encoding and write-enable decode for the dmem arbiter.
// Pure definitions; no timing or backpressure of its own.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_EXT_RD = 2'd2
  } owner_e;

  // CPU enables are low active, so all-ones means no byte is written.
  function automatic logic cpu_is_read(input logic [1:0] wen_n);
    return wen_n == 2'b11;
  endfunction

  function automatic logic ext_is_read(input logic [1:0] we);
    return we == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_arbiter_fifo.sv
// Synchronous request FIFO with occupancy count; data visible at head one cycle after push.
// Caller must not push when full or pop when empty; no push-through.
module dmem_arb_fifo #(
  parameter int DATA_W = 28,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] head_dat,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] store_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push && !rst) store_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = store_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares dmem between the CPU (always wins, zero added latency) and a queued secondary requester.
// Responses one cycle after issue; ext_req_ready drops when the queue is full or in reset.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter int EXT_DEPTH     = 4,
  parameter int STARVE_CYCLES = 256
) (
  input  logic                         mclk,
  input  logic                         puc_rst,
  input  logic                         cpu_dmem_cen,
  input  logic [1:0]                   cpu_dmem_wen,
  input  logic [ADDR_W-1:0]            cpu_dmem_addr,
  input  logic [15:0]                  cpu_dmem_din,
  output logic [15:0]                  cpu_dmem_dout,
  input  logic                         ext_req_valid,
  output logic                         ext_req_ready,
  input  logic [1:0]                   ext_req_we,
  input  logic [ADDR_W-1:0]            ext_req_addr,
  input  logic [15:0]                  ext_req_wdata,
  output logic                         ext_rsp_valid,
  output logic [15:0]                  ext_rsp_rdata,
  output logic [$clog2(EXT_DEPTH):0]   ext_pending,
  output logic                         ext_starved,
  output logic                         mem_cen,
  output logic [1:0]                   mem_wen,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [15:0]                  mem_din,
  input  logic [15:0]                  mem_dout
);

  localparam int CNT_W  = $clog2(EXT_DEPTH) + 1;
  localparam int REQ_W  = 2 + ADDR_W + 16;
  localparam int WAIT_W = $clog2(STARVE_CYCLES + 1);

  logic [CNT_W-1:0]  fifo_count;
  logic [REQ_W-1:0]  head_dat;
  logic [1:0]        head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [15:0]       head_wdata;
  logic              q_nonempty;
  logic              cpu_act;
  logic              ext_issue;
  logic              push;

  owner_e            owner_q, owner_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              starved_q, starved_d;

  assign {head_we, head_addr, head_wdata} = head_dat;

  assign q_nonempty    = fifo_count != '0;
  assign cpu_act       = !cpu_dmem_cen;
  assign ext_issue     = !cpu_act && q_nonempty && !puc_rst;
  assign ext_req_ready = (fifo_count < CNT_W'(EXT_DEPTH)) && !puc_rst;
  assign push          = ext_req_valid && ext_req_ready;

  dmem_arb_fifo #(
    .DATA_W (REQ_W),
    .DEPTH  (EXT_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk      (mclk),
    .rst      (puc_rst),
    .push     (push),
    .push_dat ({ext_req_we, ext_req_addr, ext_req_wdata}),
    .pop      (ext_issue),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  always_comb begin
    mem_cen  = 1'b1;
    mem_wen  = 2'b11;
    mem_addr = '0;
    mem_din  = '0;
    owner_d  = OWN_NONE;
    if (cpu_act) begin
      mem_cen  = 1'b0;
      mem_wen  = cpu_dmem_wen;
      mem_addr = cpu_dmem_addr;
      mem_din  = cpu_dmem_din;
      owner_d  = cpu_is_read(cpu_dmem_wen) ? OWN_CPU_RD : OWN_NONE;
    end else if (ext_issue) begin
      mem_cen  = 1'b0;
      mem_wen  = ~head_we;
      mem_addr = head_addr;
      mem_din  = head_wdata;
      owner_d  = ext_is_read(head_we) ? OWN_EXT_RD : OWN_NONE;
    end
  end

  // Waiting only counts while the CPU is actually holding the memory.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (ext_issue) begin
      wait_cnt_d = '0;
    end else if (q_nonempty && cpu_act && wait_cnt_q != WAIT_W'(STARVE_CYCLES)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    starved_d = wait_cnt_d == WAIT_W'(STARVE_CYCLES);
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      owner_q    <= OWN_NONE;
      wait_cnt_q <= '0;
      starved_q  <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      starved_q  <= starved_d;
    end
  end

  // Gating with reset suppresses a response whose issue preceded the reset edge.
  assign cpu_dmem_dout = (owner_q == OWN_CPU_RD && !puc_rst) ? mem_dout : 16'h0000;
  assign ext_rsp_valid = (owner_q == OWN_EXT_RD) && !puc_rst;
  assign ext_rsp_rdata = ext_rsp_valid ? mem_dout : 16'h0000;
  assign ext_pending   = puc_rst ? '0 : fifo_count;
  assign ext_starved   = starved_q && !puc_rst;

endmodule
